// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared FSM state encoding, CRC-8 polynomial and default chain length for the loader
package ccff_loader_pkg;
   localparam int CHAIN_LEN_DEFAULT = 18;
   localparam logic [7:0] CRC8_POLY = 8'h07;
   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial: MSB-first serial CRC-8 accumulator, one bit per enabled cycle
//   clk, reset (async, active-high) | clear: sync zero | enable, bit_in: fold one bit | crc: running value
module ccff_crc8_serial
   import ccff_loader_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [7:0] crc
);
   logic fb;
   assign fb = crc[7] ^ bit_in;
   always_ff @(posedge clk or posedge reset)
      if (reset) crc <= '0;
      else if (clear) crc <= '0;
      else if (enable) crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: loads a configuration flip-flop chain from a byte stream, then optionally recirculates it and checks CRCs
//   prog_clk, prog_reset_n (async, active-low) | start: begin a load
//   cfg_valid/cfg_ready/cfg_data: byte stream, MSB shifted first
//   ccff_head/ccff_shift_en/ccff_tail: chain serial in, shift enable, serial out
//   busy: LOAD or VERIFY | done: completion pulse | cfg_ok: sticky CRC match flag
module ccff_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
   parameter bit VERIFY_EN = 1'b1
)(
   input  logic       prog_clk,
   input  logic       prog_reset_n,
   input  logic       start,
   input  logic       cfg_valid,
   input  logic [7:0] cfg_data,
   output logic       cfg_ready,
   output logic       ccff_head,
   output logic       ccff_shift_en,
   input  logic       ccff_tail,
   output logic       busy,
   output logic       done,
   output logic       cfg_ok
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);
   localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);

   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [7:0] sbuf;
   logic [3:0] nbits;
   logic ok_q, load_go, last_shift;
   logic [7:0] crc_a, crc_b;

   assign load_go = state == IDLE && start;
   assign last_shift = ccff_shift_en && cnt == LEN_M1;

   always_ff @(posedge prog_clk or negedge prog_reset_n)
      if (!prog_reset_n) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      cfg_ready = 1'b0;
      ccff_shift_en = 1'b0;
      ccff_head = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      cfg_ok = ok_q;
      case (state)
         IDLE: state_n = start ? LOAD : IDLE;
         LOAD: begin
            busy = 1'b1;
            ccff_shift_en = nbits != 4'd0 && cnt < LEN;
            ccff_head = ccff_shift_en & sbuf[7];
            // refill in the same cycle the last buffered bit leaves, unless that shift completes the chain
            cfg_ready = cnt < LEN && (nbits == 4'd0 || (ccff_shift_en && nbits == 4'd1 && cnt < LEN_M1));
            state_n = last_shift ? (VERIFY_EN ? VERIFY : DONE) : LOAD;
         end
         VERIFY: begin
            busy = 1'b1;
            ccff_shift_en = 1'b1;
            ccff_head = ccff_tail;
            state_n = cnt == LEN_M1 ? DONE : VERIFY;
         end
         DONE: begin
            done = 1'b1;
            cfg_ok = !VERIFY_EN || crc_a == crc_b;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n)
      if (!prog_reset_n) begin
         cnt <= '0;
         sbuf <= '0;
         nbits <= '0;
         ok_q <= 1'b0;
      end else begin
         if (load_go || (state == LOAD && state_n == VERIFY)) cnt <= '0;
         else if (ccff_shift_en && cnt < LEN) cnt <= cnt + CW'(1);
         if (load_go) begin
            nbits <= '0;
            ok_q <= 1'b0;
         end else if (state == LOAD) begin
            // the final shift drops whatever low bits of the last byte are left over
            if (last_shift) nbits <= '0;
            else if (cfg_valid && cfg_ready) begin
               sbuf <= cfg_data;
               nbits <= 4'd8;
            end else if (ccff_shift_en) begin
               sbuf <= {sbuf[6:0], 1'b0};
               nbits <= nbits - 4'd1;
            end
         end
         if (state == DONE) ok_q <= cfg_ok;
      end

   ccff_crc8_serial u_crc_a (
      .clk(prog_clk), .reset(!prog_reset_n), .clear(load_go),
      .enable(state == LOAD && ccff_shift_en), .bit_in(ccff_head), .crc(crc_a)
   );

   ccff_crc8_serial u_crc_b (
      .clk(prog_clk), .reset(!prog_reset_n), .clear(load_go),
      .enable(state == VERIFY), .bit_in(ccff_tail), .crc(crc_b)
   );
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed bench for ccff_loader with chain models and a head-bit scoreboard
module tb_ccff_loader;
   localparam int L = 18;
   localparam logic [L-1:0] EXP = 18'b101001010011110011;

   logic prog_clk, prog_reset_n, start, cfg_valid;
   logic [7:0] cfg_data;
   logic cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, cfg_ok;
   logic cfg_ready0, head0, shift_en0, tail0, busy0, done0, cfg_ok0;
   logic [L-1:0] chain, chain0;
   int n_shift;
   bit inject;
   int vectors, errs;
   logic head_q[$];
   logic ok_q[$];

   ccff_loader #(.CHAIN_LEN(L), .VERIFY_EN(1'b1)) dut (
      .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .cfg_ok(cfg_ok)
   );

   ccff_loader #(.CHAIN_LEN(L), .VERIFY_EN(1'b0)) dut0 (
      .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready0),
      .ccff_head(head0), .ccff_shift_en(shift_en0), .ccff_tail(tail0),
      .busy(busy0), .done(done0), .cfg_ok(cfg_ok0)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   initial begin
      chain = '0;
      chain0 = '0;
      n_shift = 0;
   end

   always @(posedge prog_clk) begin
      if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
      if (shift_en0) chain0 <= {chain0[L-2:0], head0};
      if (start && !busy) n_shift <= 0;
      else if (ccff_shift_en) n_shift <= n_shift + 1;
   end

   // optional single-bit corruption on the 5th recirculation cycle
   assign ccff_tail = chain[L-1] ^ (inject && n_shift == L + 4);
   assign tail0 = chain0[L-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int stall, input bit inj, input int abort_at, input bit extra);
      logic [7:0] by [3];
      logic e;
      int bi, gap, s18, d0, bub, vs, sh0;
      bit fin;
      by = '{8'hA5, 8'h3C, 8'hC0};
      bi = 0; gap = 0; s18 = -1; d0 = -1; bub = 0; vs = 0; sh0 = 0; fin = 0;
      head_q.delete();
      ok_q.delete();
      for (int i = 0; i < L; i++) begin
         logic [7:0] b;
         b = by[i / 8];
         head_q.push_back(b[7 - i % 8]);
      end
      ok_q.push_back(!inj);
      inject = inj;
      @(negedge prog_clk);
      start = 1'b1;
      cfg_valid = 1'b0;
      #1;
      chk("idle_busy", {31'd0, busy}, 0);
      @(negedge prog_clk);
      start = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         cfg_valid = bi < 3 && !(bi == 1 && gap < stall);
         cfg_data = by[bi < 3 ? bi : 2];
         start = extra && c == 5;
         #1;
         if (c == 0) chk("load_busy", {31'd0, busy}, 1);
         if (bi == 1 && gap < stall && cfg_ready) gap++;
         if (cfg_valid && cfg_ready) bi++;
         if (ccff_shift_en && n_shift < L) begin
            e = head_q.size() > 0 ? head_q.pop_front() : 1'bx;
            chk("load_head", {31'd0, ccff_head}, {31'd0, e});
            if (n_shift == L - 1) s18 = c;
            if (n_shift == abort_at) begin
               prog_reset_n = 1'b0;
               #1;
               chk("abort_outs", {26'd0, cfg_ready, ccff_shift_en, ccff_head, busy, done, cfg_ok}, 0);
               chk("abort_outs0", {26'd0, cfg_ready0, shift_en0, head0, busy0, done0, cfg_ok0}, 0);
               @(negedge prog_clk);
               prog_reset_n = 1'b1;
               cfg_valid = 1'b0;
               start = 1'b0;
               return;
            end
         end
         if (ccff_shift_en && n_shift >= L) begin
            vs++;
            chk("verify_loop", {31'd0, ccff_head}, {31'd0, ccff_tail});
         end
         if (busy && !ccff_shift_en && n_shift > 0 && n_shift < L) bub++;
         if (shift_en0) sh0++;
         if (done0) begin
            d0 = c;
            chk("ok_noverify", {31'd0, cfg_ok0}, 1);
         end
         if (done) begin
            fin = 1;
            chk("cfg_ok", {31'd0, cfg_ok}, {31'd0, ok_q.size() > 0 ? ok_q.pop_front() : 1'bx});
         end
         @(negedge prog_clk);
      end
      cfg_valid = 1'b0;
      start = 1'b0;
      #1;
      chk("timeout", {31'd0, fin}, 1);
      chk("bubbles", bub, stall);
      chk("verify_shifts", vs, L);
      chk("noverify_latency", d0, s18 + 1);
      chk("noverify_shifts", sh0, L);
      chk("chain0", {14'd0, chain0}, {14'd0, EXP});
      if (!inj) chk("chain", {14'd0, chain}, {14'd0, EXP});
      chk("after_done", {29'd0, done, busy, cfg_ready}, 0);
      chk("ok_sticky", {31'd0, cfg_ok}, {31'd0, !inj});
      chk("ok_sticky0", {31'd0, cfg_ok0}, 1);
   endtask

   initial begin
      vectors = 0;
      errs = 0;
      inject = 0;
      prog_reset_n = 1'b0;
      start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data = 8'h00;
      #12;
      chk("reset_outs", {26'd0, cfg_ready, ccff_shift_en, ccff_head, busy, done, cfg_ok}, 0);
      chk("reset_outs0", {26'd0, cfg_ready0, shift_en0, head0, busy0, done0, cfg_ok0}, 0);
      @(negedge prog_clk);
      prog_reset_n = 1'b1;
      run(0, 0, -1, 0);
      run(3, 0, -1, 0);
      run(0, 1, -1, 0);
      run(0, 0, 8, 0);
      run(0, 0, -1, 0);
      run(0, 0, -1, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter: CHAIN_LEN, default 18, number of configuration-chain flops driven (one BLE4: 16 LUT bits plus 2 output-mux bits); legal range 1..65535.
REQ-002 Parameter: VERIFY_EN, default 1, enables the recirculate-and-check pass after load.
REQ-003 Port: prog_clk, input, 1, single clock; the chain shifts on its rising edge.
REQ-004 Port: prog_reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, single-cycle request to begin a load.
REQ-006 Port: cfg_valid, input, 1, a bitstream byte is offered.
REQ-007 Port: cfg_data, input, 8, bitstream byte; bit 7 is shifted first.
REQ-008 Port: cfg_ready, output, 1, loader accepts cfg_data this cycle.
REQ-009 Port: ccff_head, output, 1, serial bit to chain head.
REQ-010 Port: ccff_shift_en, output, 1, enable for the external prog_clk gate; the chain shifts only in cycles where it is 1.
REQ-011 Port: ccff_tail, input, 1, serial bit returned from chain tail.
REQ-012 Port: busy, output, 1, high from start acceptance until done.
REQ-013 Port: done, output, 1, one-cycle pulse at completion.
REQ-014 Port: cfg_ok, output, 1, sticky pass flag, valid once done has pulsed.

Function
REQ-015 States SHALL be IDLE, LOAD, VERIFY, DONE.
- IDLE->LOAD on start.
- LOAD->VERIFY after CHAIN_LEN shifts when VERIFY_EN=1, otherwise LOAD->DONE.
- VERIFY->DONE after CHAIN_LEN shifts.
- DONE->IDLE the next cycle.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 On entering LOAD, the shift counter, CRC_A, CRC_B and cfg_ok SHALL clear to 0.
REQ-018 A byte transfers on cfg_valid&&cfg_ready. In LOAD, cfg_ready SHALL be 1 when:
- the byte buffer is empty, or
- the last buffered bit shifts this cycle and shifts remaining exceed 1.
REQ-019 In LOAD, ccff_shift_en SHALL be 1 exactly when the buffer holds a bit and fewer than CHAIN_LEN shifts are done; ccff_head = buffer MSB in that cycle.
REQ-020 Continuous cfg_valid SHALL sustain one shift per cycle with no bubbles; a cfg_valid gap SHALL hold ccff_shift_en low with no bit lost.
REQ-021 After shift CHAIN_LEN, unshifted low bits of the final byte SHALL be discarded; cfg_ready=0 from then on.
REQ-022 In VERIFY, ccff_shift_en=1 for exactly CHAIN_LEN consecutive cycles; ccff_head = ccff_tail combinationally, so the chain ends holding the loaded contents.
REQ-023 CRC-8 (poly 0x07, init 0x00, MSB-first serial) SHALL be updated:
- CRC_A with each shifted head bit in LOAD;
- CRC_B with each sampled ccff_tail bit in VERIFY.
REQ-024 On entering DONE, cfg_ok SHALL be 1 if VERIFY_EN=0 or CRC_A==CRC_B, else 0; done pulses for that cycle.
REQ-025 busy=1 in LOAD and VERIFY only; ccff_shift_en=0 in IDLE and DONE; ccff_head=0 when ccff_shift_en=0.
REQ-026 The shift counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and SHALL not wrap; it saturates at CHAIN_LEN.

Reset
REQ-027 prog_reset_n low SHALL asynchronously force:
- state IDLE and the buffer empty;
- counter and both CRCs to 0;
- cfg_ready, ccff_shift_en, ccff_head, busy, done and cfg_ok to 0.
REQ-028 Reset asserted mid-LOAD or mid-VERIFY SHALL abandon the operation; chain contents are then undefined, and only a fresh start recovers.

Structure
REQ-029 The state enum, CRC polynomial and default CHAIN_LEN SHALL live in shared package ccff_loader_pkg.
REQ-030 The serial CRC update SHALL be sub-module ccff_crc8_serial (inputs: clk, reset, clear, enable, bit; output: crc[7:0]), instantiated twice.

Verification
REQ-031 The bench SHALL model the chain as a CHAIN_LEN-bit shift register clocked when ccff_shift_en=1.
REQ-032 Basic load, CHAIN_LEN=18, bytes 0xA5,0x3C,0xC0, cfg_valid held:
- 18 consecutive shift cycles;
- model holds bits 101001010011110011 (first shifted at tail end);
- done pulses; cfg_ok=1.
REQ-033 Stall: cfg_valid dropped for 3 cycles after byte 1 -> ccff_shift_en low for those cycles; final model contents identical to the basic load.
REQ-034 Fault injection: bench flips ccff_tail on the 5th VERIFY cycle -> done pulses, cfg_ok=0.
REQ-035 Reset at LOAD shift 9 -> all outputs 0 immediately, state IDLE; a following start then completes a full load with cfg_ok=1.
REQ-036 start asserted during LOAD, and VERIFY_EN=0 run -> extra start ignored; with VERIFY_EN=0, done follows shift 18 by one cycle with cfg_ok=1 and no VERIFY shifts.
